// File: rtl/uart_mmio_ctrl_if.sv
// Peripheral bus bundle between the MEM stage and the UART controller.
//
// Handshake: wr and rd are single-cycle strobes with no ready/stall. A store
// is taken on the rising edge where wr=1 (addr/wdata valid with it). rdata is
// a pure combinational function of addr, so it is valid in every cycle; rd
// only qualifies read side effects (flag clears) on the edge where it is 1.
// irq is a level that the CPU polls or takes as an interrupt.
//
// Signals:
//   addr   32  byte address
//   wdata  32  store data
//   wr      1  store strobe
//   rd      1  load strobe
//   rdata  32  load data (0 for unmapped addresses)
//   irq     1  interrupt request
interface uart_mmio_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr, wdata, wr, rd,
    input  rdata, irq
  );

  modport slave (
    input  addr, wdata, wr, rd,
    output rdata, irq
  );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: turns CPU stores/loads at fixed peripheral
// addresses into 8N1 byte transmit/receive and raises a level interrupt on TX
// completion or RX arrival.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-low
//   bus           peripheral bus (slave modport): addr, wdata, wr, rd, rdata, irq
//   UART_RX       asynchronous serial input
//   UART_TX       serial output, idle high
//   dbg_tx_state  current TX FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//   dbg_rx_state  current RX FSM state (same encoding)
//
// Register map (word addresses, upper rdata bits zero):
//   0x4000_0018 TXD  W  [7:0] byte to send, ignored while tx_busy
//   0x4000_001C RXD  R  [7:0] last received byte; rd clears rx_valid
//   0x4000_0020 CON     [0] tx_irq_en [1] rx_irq_en [2] tx_done [3] rx_valid
//                       [4] tx_busy [5] rx_overrun; rd clears tx_done/rx_overrun
module uart_mmio_ctrl #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic             clk,
  input  logic             reset,
  uart_mmio_ctrl_if.slave  bus,
  input  logic             UART_RX,
  output logic             UART_TX,
  output logic [1:0]       dbg_tx_state,
  output logic [1:0]       dbg_rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0]   ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0]   ADDR_CON  = 32'h4000_0020;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // TX path
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]    tx_bit_q,   tx_bit_d;
  logic [7:0]    tx_byte_q,  tx_byte_d;
  logic          tx_line_q,  tx_line_d;
  logic          tx_busy_q,  tx_busy_d;
  logic          tx_done_q,  tx_done_d;
  logic          tx_finish;

  // RX path
  logic          rx_sync1_q,  rx_sync1_d;
  logic          rx_sync2_q,  rx_sync2_d;
  uart_state_e   rx_state_q,  rx_state_d;
  logic [CW-1:0] rx_cnt_q,    rx_cnt_d;
  logic [2:0]    rx_bit_q,    rx_bit_d;
  logic [7:0]    rx_shift_q,  rx_shift_d;
  logic [7:0]    rx_data_q,   rx_data_d;
  logic          rx_valid_q,  rx_valid_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          rx_load;

  // Control
  logic tx_irq_en_q, tx_irq_en_d;
  logic rx_irq_en_q, rx_irq_en_d;

  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic unused_wdata;

  assign wr_txd = bus.wr && (bus.addr == ADDR_TXD);
  assign wr_con = bus.wr && (bus.addr == ADDR_CON);
  assign rd_rxd = bus.rd && (bus.addr == ADDR_RXD);
  assign rd_con = bus.rd && (bus.addr == ADDR_CON);
  assign unused_wdata = ^bus.wdata[31:8];

  // ---------------------------------------------------------------- TX
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = tx_done_q;
    tx_line_d  = 1'b1;
    tx_finish  = 1'b0;

    // tx_busy_q is the pre-edge value, so a write on the edge where the stop
    // bit ends is still rejected.
    if (wr_txd && !tx_busy_q) begin
      tx_byte_d = bus.wdata[7:0];
      tx_busy_d = 1'b1;
    end

    case (tx_state_q)
      S_IDLE: begin
        // Busy while idle means a byte was accepted on the previous edge;
        // the frame starts one cycle after the accepting edge.
        if (tx_busy_q) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_finish  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so it changes on the same
    // edge as the state, glitch-free.
    case (tx_state_d)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_byte_q[tx_bit_d];
      default: tx_line_d = 1'b1;
    endcase

    if (tx_finish) tx_busy_d = 1'b0;
    // Completion wins over a simultaneous CON read clear.
    if (rd_con)    tx_done_d = 1'b0;
    if (tx_finish) tx_done_d = 1'b1;
  end

  // ---------------------------------------------------------------- RX
  always_comb begin
    rx_sync1_d   = UART_RX;
    rx_sync2_d   = rx_sync1_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    rx_load      = 1'b0;

    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects short glitches.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_load    = rx_sync2_q;  // stop=0 is a framing error: drop byte
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase

    if (rx_load) rx_data_d = rx_shift_q;

    if (rd_rxd)  rx_valid_d = 1'b0;
    if (rx_load) rx_valid_d = 1'b1;

    // A byte arriving while the old one is read in the same cycle is not an
    // overrun: the old byte was consumed.
    if (rd_con) rx_overrun_d = 1'b0;
    if (rx_load && rx_valid_q && !rd_rxd) rx_overrun_d = 1'b1;
  end

  // ---------------------------------------------------------------- CON
  always_comb begin
    tx_irq_en_d = tx_irq_en_q;
    rx_irq_en_d = rx_irq_en_q;
    if (wr_con) begin
      tx_irq_en_d = bus.wdata[0];
      rx_irq_en_d = bus.wdata[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= 3'd0;
      tx_byte_q    <= 8'd0;
      tx_line_q    <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_irq_en_q  <= 1'b0;
      rx_irq_en_q  <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_byte_q    <= tx_byte_d;
      tx_line_q    <= tx_line_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
      rx_sync1_q   <= rx_sync1_d;
      rx_sync2_q   <= rx_sync2_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_irq_en_q  <= tx_irq_en_d;
      rx_irq_en_q  <= rx_irq_en_d;
    end
  end

  // Read data is decoded from addr alone; rd never gates it.
  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      ADDR_RXD: bus.rdata = {24'd0, rx_data_q};
      ADDR_CON: bus.rdata = {26'd0, rx_overrun_q, tx_busy_q, rx_valid_q,
                             tx_done_q, rx_irq_en_q, tx_irq_en_q};
      default:  bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq      = (tx_done_q & tx_irq_en_q) | (rx_valid_q & rx_irq_en_q);
  assign UART_TX      = tx_line_q;
  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped UART controller that sequences the serial TX/RX datapath behind the CPU's peripheral bus. It owns the UART_TX/UART_RX pins, converts CPU loads/stores at fixed peripheral addresses into byte transmit/receive operations, and raises an interrupt request on TX completion or RX arrival. It sits beside the LED/switch/digit peripherals in the MEM-stage address decode of Pipeline_CPU.

## Interface
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 4.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; state cleared on a rising edge of clk while reset=0
- addr  in  32  byte address from the MEM stage
- wdata  in  32  store data
- wr  in  1  store strobe, one cycle per access
- rd  in  1  load strobe, one cycle per access; qualifies read side effects only
- rdata  out  32  load data, combinational from addr; 0 for unmapped addresses
- irq  out  1  interrupt request, level
- UART_RX  in  1  serial input, asynchronous
- UART_TX  out  1  serial output, idle high

## Operation
- Register map, word addresses, upper rdata bits zero:
  - 0x4000_0018 TXD (W): [7:0] byte to send. Accepted only when tx_busy=0; otherwise ignored. Reads return 0.
  - 0x4000_001C RXD (R): [7:0] last received byte. A read with rd=1 clears rx_valid.
  - 0x4000_0020 CON: [0] tx_irq_en (RW), [1] rx_irq_en (RW), [2] tx_done (RO, sticky), [3] rx_valid (RO), [4] tx_busy (RO), [5] rx_overrun (RO, sticky). A read with rd=1 clears tx_done and rx_overrun; writes affect only [1:0].
- irq = (tx_done & tx_irq_en) | (rx_valid & rx_irq_en).
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE. Each state bit lasts CLKS_PER_BIT cycles. Entering STOP→IDLE sets tx_done and clears tx_busy. tx_busy=1 from the accepting write edge until the stop bit ends.
- RX path: UART_RX passes through a 2-flop synchronizer. FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a sampled 0 enters START.
  - START: after CLKS_PER_BIT/2 cycles resample; 1 = glitch, return to IDLE; 0 = continue.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, load RXD and set rx_valid. If rx_valid was already 1, also set rx_overrun; the new byte overwrites. If 0 (framing error), discard the byte, flags unchanged. Return to IDLE either way.
- Simultaneous events:
  - RXD read in the same cycle as byte arrival: new byte loads, rx_valid stays 1, no overrun.
  - CON read in the same cycle as TX completion: tx_done ends 1.
  - CON read in the same cycle as overrun: rx_overrun ends 1.
  - TXD write in the same cycle tx_busy falls: ignored, because tx_busy is sampled before update.
- Reset mid-frame: both FSMs abort to IDLE; UART_TX returns high on the next edge. The partial RX byte is lost.

## Timing
- Reset values: UART_TX=1, irq=0, all CON bits 0, RXD=0, both FSMs IDLE, bit counters 0.
- TXD write accepted at edge k: UART_TX=0 from edge k+1.
  - Data bit n drives from k+1+(n+1)·CLKS_PER_BIT.
  - Stop bit is high from k+1+9·CLKS_PER_BIT.
  - tx_busy falls and tx_done rises at edge k+1+10·CLKS_PER_BIT.
- RX latency: 2 cycles of synchronizer delay. rx_valid rises 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the falling edge of the start bit on the pin, ±1 cycle.
- Register writes and flag clears take effect at the edge where the strobe is sampled. irq reflects the updated flags on the following cycle.

## Test plan
Run with CLKS_PER_BIT=16.
- Reset: hold reset=0 for 2 clocks → UART_TX=1, irq=0; a read of CON returns 0x0000_0000.
- TX: write 0x55 to TXD → start bit low for 16 cycles, then 1,0,1,0,1,0,1,0, then stop high. A CON read mid-frame returns 0x10. After 160+1 cycles CON=0x04; the next CON read returns 0x00.
- TX busy write: write 0xA3, then write 0xFF 20 cycles later → the line shows only the 0xA3 frame; the second write is dropped.
- RX + irq: write CON=0x2, drive frame 0x3C on UART_RX → RXD reads 0x3C, irq=1; after the RXD read, irq=0 and CON[3]=0.
- RX overrun/framing: send 0x11 then 0x22 without reading → RXD=0x22, CON[5]=1. Send a frame with stop=0 → RXD unchanged. A 4-cycle low glitch → no byte received.
- Reset mid-TX: assert reset 50 cycles into a frame → UART_TX=1 on the next edge, CON=0; a new TXD write then transmits normally.
